// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write arbiter
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int STAT_W = 8;   // width of per-requester accepted-beat counters
   localparam int CNT_W  = 8;   // beat counter width, covers MAX_BURST up to 255

   // Index width for a requester vector; never narrower than one bit.
   function automatic int req_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational round-robin priority pick
//
// Purpose: finds the first asserted bit of valid, searching from last_ptr+1
//          upward and wrapping, so the previous owner has lowest priority.
// Ports:
//   valid    in  NUM_REQ  request vector
//   last_ptr in  IDX_W    index of the previous owner
//   found    out 1        some request is asserted
//   index    out IDX_W    winning index (0 when nothing found)
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   last_ptr,
   output logic               found,
   output logic [IDX_W-1:0]   index
);

   int               w_sum;
   logic [IDX_W-1:0] w_idx;

   // Scan from the farthest candidate down to the nearest; the last hit
   // written is therefore the nearest one after last_ptr.
   always_comb begin
      found = 1'b0;
      index = '0;
      w_sum = 0;
      w_idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_sum = int'(last_ptr) + k;
         if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
         end
         w_idx = w_sum[IDX_W-1:0];
         if (valid[w_idx]) begin
            found = 1'b1;
            index = w_idx;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter for a CDC FIFO write port
//
// Purpose: shares the FIFO write port among NUM_REQ requesters. One owner at a
//          time moves up to MAX_BURST beats; FIFO full stalls the burst.
// Optional feature macro: FIFO_ARB_STATS_EN (per-requester beat counters).
// Ports:
//   clk, rst_n    clock and async active-low reset
//   req_valid     in  NUM_REQ     per-requester beat valid
//   req_last      in  NUM_REQ     final beat of requester packet
//   req_data      in  NUM_REQ*DW  requester i data at [i*DW +: DW]
//   req_ready     out NUM_REQ     beat accepted when valid & ready
//   fifo_full     in  1           FIFO full flag
//   fifo_wr_inc   out 1           FIFO write_increment
//   fifo_wr_data  out DATA_WIDTH  FIFO write_data
//   grant         out NUM_REQ     one-hot owner, 0 when idle
//   busy          out 1           burst in progress
//   stat_sel      in  log2(N)     (FIFO_ARB_STATS_EN) counter select
//   stat_count    out 8           (FIFO_ARB_STATS_EN) selected counter
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 4,
   parameter int MAX_BURST  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_inc,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
   output logic [STAT_W-1:0]             stat_count
`endif
);

   localparam int IDX_W = req_idx_w(NUM_REQ);

   arb_state_t            r_state, w_state_nxt;
   logic [IDX_W-1:0]      r_owner, w_owner_nxt;
   logic [IDX_W-1:0]      r_last_ptr, w_last_ptr_nxt;
   logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;
   logic [CNT_W-1:0]      w_cnt_inc;
   logic [IDX_W-1:0]      w_pick;
   logic                  w_found;
   logic                  w_burst;
   logic                  w_owner_valid;
   logic                  w_owner_last;
   logic                  w_accept;
   logic [DATA_WIDTH-1:0] w_owner_data;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .valid    (req_valid),
      .last_ptr (r_last_ptr),
      .found    (w_found),
      .index    (w_pick)
   );

   assign w_burst       = (r_state == BURST);
   assign w_owner_valid = req_valid[r_owner];
   assign w_owner_last  = req_last[r_owner];
   assign w_owner_data  = req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
   assign w_accept      = w_burst & w_owner_valid & ~fifo_full;
   assign w_cnt_inc     = r_beat_cnt + 1'b1;

   assign busy         = w_burst;
   assign fifo_wr_inc  = w_accept;
   assign fifo_wr_data = w_accept ? w_owner_data : '0;

   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_last_ptr_nxt = r_last_ptr;
      w_beat_cnt_nxt = r_beat_cnt;
      req_ready      = '0;
      grant          = '0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt    = BURST;
               w_owner_nxt    = w_pick;
               w_beat_cnt_nxt = '0;
            end
         end
         BURST: begin
            req_ready[r_owner] = ~fifo_full;
            grant[r_owner]     = 1'b1;
            // Owner dropping valid releases the port even when the FIFO is full.
            if (!w_owner_valid) begin
               w_state_nxt    = IDLE;
               w_last_ptr_nxt = r_owner;
            end else if (!fifo_full) begin
               w_beat_cnt_nxt = w_cnt_inc;
               if (w_owner_last || (w_cnt_inc == CNT_W'(MAX_BURST))) begin
                  w_state_nxt    = IDLE;
                  w_last_ptr_nxt = r_owner;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_owner    <= '0;
         r_last_ptr <= IDX_W'(NUM_REQ - 1);
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_last_ptr <= w_last_ptr_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] r_stat [NUM_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_stat[i] <= '0;
         end
      end else if (w_accept && (r_stat[r_owner] != '1)) begin
         r_stat[r_owner] <= r_stat[r_owner] + 1'b1;
      end
   end

   assign stat_count = (int'(stat_sel) < NUM_REQ) ? r_stat[stat_sel] : '0;
`endif

endmodule
